data_mem: RTL and testbench
===========================

DATA_MEM -- requirements
Module: data_mem

Interface
REQ-001 SHALL have parameter W, default 8: data word width in bits.
REQ-002 SHALL have parameter A, default 8: address width in bits; depth is 2**A words (256 at default).
REQ-003 SHALL have port clk, input, 1: single clock; all writes occur on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port WriteMem, input, 1: write enable.
REQ-006 SHALL have port ReadMem, input, 1: read enable.
REQ-007 SHALL have port DataAddress, input, A: word address for both read and write.
REQ-008 SHALL have port DataIn, input, W: write data.
REQ-009 SHALL have port DataOut, output, W: read data.

Function
REQ-010 SHALL store contents in an unpacked array named mem_core, indexed 0 to 2**A-1, each entry W bits wide.
- Testbenches preload and inspect it hierarchically (e.g. data_mem1.mem_core[5]).
- The name and index order are fixed.
REQ-011 SHALL drive DataOut combinationally with mem_core[DataAddress] while ReadMem=1 and reset_n=1, with zero cycles of latency.
REQ-012 SHALL drive DataOut to all-zeros while ReadMem=0 or reset_n=0.
REQ-013 SHALL write DataIn into mem_core[DataAddress] on a rising clk edge when WriteMem=1 and reset_n=1; all other locations are left unchanged.
REQ-014 SHALL ignore WriteMem=0 edges; contents hold indefinitely.
REQ-015 SHALL, for a simultaneous read and write to the same address, present the old value before the edge and the new value immediately after the edge (no bypass).
REQ-016 SHALL allow read and write to proceed in the same cycle; only one address exists, so both target DataAddress.
REQ-017 SHALL cover every address value, 0 and 2**A-1 included, with no wrap-around or aliasing.
REQ-018 SHALL drop any write edge that coincides with reset_n=0 (reset dominates).
REQ-019 SHALL contain no state machine; the block is a single-port RAM with a combinational read path.

Reset
REQ-020 SHALL act on reset_n=0 immediately, independent of clk.
REQ-021 SHALL hold DataOut at 0 and block all writes while reset_n=0.
REQ-022 SHALL leave memory contents unaffected by reset unless DATA_MEM_RESET_CLEAR_EN is defined (REQ-024).
REQ-023 SHALL resume normal read and write behaviour on the first rising clk edge after reset_n returns to 1.

Configuration
REQ-024 SHALL, when macro DATA_MEM_RESET_CLEAR_EN is defined, asynchronously clear all 2**A entries of mem_core to 0 while reset_n=0.
REQ-025 SHALL, when DATA_MEM_RESET_CLEAR_EN is not defined, retain mem_core contents through reset, so values preloaded hierarchically before or during reset survive.

Verification
REQ-026 Preload: hierarchically set mem_core[4]=8'h3C and mem_core[5]=8'h80; ReadMem=1; address 4 then 5 -> DataOut=8'h3C then 8'h80 in the same cycle.
REQ-027 Write: WriteMem=1, address 8'h06, DataIn=8'hFF, one clk edge -> mem_core[6]=8'hFF and mem_core[7] unchanged.
REQ-028 Same-address read/write: address 8'h10 holding 8'h11, DataIn=8'h22, both enables high -> DataOut=8'h11 before the edge and 8'h22 after it.
REQ-029 Boundaries: write 8'hA5 to address 8'hFF and 8'h5A to address 8'h00 -> both read back exactly; no other location is changed.
REQ-030 Read disabled: ReadMem=0 at any address -> DataOut=8'h00.
REQ-031 Reset mid-operation: assert reset_n=0 between clock edges while WriteMem=1 -> DataOut=0 at once and no write occurs.
- With DATA_MEM_RESET_CLEAR_EN: all locations read 0 after release.
- Without it: prior contents (e.g. mem_core[6]=8'hFF) are intact.

Source files
------------

// File: rtl/data_mem.sv
// Single-port data RAM with an asynchronous combinational read and a synchronous write.
// Build option: define DATA_MEM_RESET_CLEAR_EN to clear every entry while reset_n is low.
module data_mem #(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         WriteMem,
  input  logic         ReadMem,
  input  logic [A-1:0] DataAddress,
  input  logic [W-1:0] DataIn,
  output logic [W-1:0] DataOut
);

  localparam int DEPTH = 2 ** A;

  // Storage is probed and preloaded by name from outside; keep name and index order.
  logic [W-1:0] mem_core [0:DEPTH-1];

  logic write_en;
  assign write_en = WriteMem && reset_n;

`ifdef DATA_MEM_RESET_CLEAR_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_core[i] <= '0;
      end
    end else if (write_en) begin
      mem_core[DataAddress] <= DataIn;
    end
  end
`else
  // Contents survive reset; a low reset_n at the edge simply suppresses the write.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_core[DataAddress] <= DataIn;
    end
  end
`endif

  // No write bypass: a same-cycle write only becomes visible after the edge.
  always_comb begin
    DataOut = '0;
    if (ReadMem && reset_n) begin
      DataOut = mem_core[DataAddress];
    end
  end

endmodule

// File: tb/tb_data_mem.sv
// Scoreboard bench for data_mem: stimulus pushes expectations, a negedge monitor checks them.
module tb_data_mem;

  logic       clk;
  logic       reset_n;
  logic       WriteMem;
  logic       ReadMem;
  logic [7:0] DataAddress;
  logic [7:0] DataIn;
  logic [7:0] DataOut;

  data_mem #(.W(8), .A(8)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .WriteMem   (WriteMem),
    .ReadMem    (ReadMem),
    .DataAddress(DataAddress),
    .DataIn     (DataIn),
    .DataOut    (DataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    bit         is_mem;
    int         addr;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] model [256];
  int         total = 0;
  int         bad   = 0;

  // Monitor: everything queued since the last rising edge is checked at the falling edge.
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = e.is_mem ? dut.mem_core[e.addr] : DataOut;
      total++;
      if (act !== e.exp) begin
        bad++;
        $display("FAIL %s addr=%02h got=%02h want=%02h", e.name, e.addr, act, e.exp);
      end else if (!e.is_mem) begin
        $display("ok   %s addr=%02h data=%02h", e.name, e.addr, act);
      end
    end
  end

  task automatic push_exp(input string name, input bit is_mem, input int addr,
                          input logic [7:0] exp);
    exp_t e;
    e.name   = name;
    e.is_mem = is_mem;
    e.addr   = addr;
    e.exp    = exp;
    sb_q.push_back(e);
  endtask

  // One bus cycle: drive after the edge, expect the pre-edge contents, commit the write.
  task automatic drive(input string name, input bit we, input bit re,
                       input logic [7:0] addr, input logic [7:0] din);
    @(posedge clk);
    #1;
    WriteMem    = we;
    ReadMem     = re;
    DataAddress = addr;
    DataIn      = din;
    push_exp(name, 1'b0, int'(addr), (re && reset_n) ? model[addr] : 8'h00);
    if (we && reset_n) model[addr] = din;
  endtask

  // Call only right after a non-writing drive so the model and DUT array agree.
  task automatic inspect(input string name, input int addr);
    push_exp(name, 1'b1, addr, model[addr]);
  endtask

  task automatic sweep(input string name);
    for (int i = 0; i < 256; i++) inspect(name, i);
  endtask

  initial begin
    reset_n     = 1'b0;
    WriteMem    = 1'b0;
    ReadMem     = 1'b1;
    DataAddress = 8'h04;
    DataIn      = 8'h00;

    // Preload random contents while in reset; they must survive unless clearing is built in.
    #1;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] v;
      v = 8'($urandom);
      dut.mem_core[i] <= v;
      model[i] = v;
    end
    push_exp("reset_out", 1'b0, 4, 8'h00);
`ifdef DATA_MEM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
`endif
    drive("reset_wr_blocked", 1'b1, 1'b1, 8'h20, 8'hEE);
    drive("reset_rd", 1'b0, 1'b1, 8'h20, 8'h00);
    @(negedge clk);
    #1 reset_n = 1'b1;
    drive("post_reset_rd20", 1'b0, 1'b1, 8'h20, 8'h00);
    sweep("retain_after_reset");

    // Hierarchical preload, read back with zero latency
    @(posedge clk);
    #1;
    dut.mem_core[4] <= 8'h3C;
    dut.mem_core[5] <= 8'h80;
    model[4] = 8'h3C;
    model[5] = 8'h80;
    drive("preload4", 1'b0, 1'b1, 8'h04, 8'h00);
    drive("preload5", 1'b0, 1'b1, 8'h05, 8'h00);

    // Single write; neighbour untouched
    model[7] = 8'h77;
    dut.mem_core[7] <= 8'h77;
    drive("write6", 1'b1, 1'b0, 8'h06, 8'hFF);
    drive("rd6", 1'b0, 1'b1, 8'h06, 8'h00);
    inspect("mem6", 6);
    inspect("mem7", 7);

    // Same-address read/write: old before edge, new after
    drive("setup10", 1'b1, 1'b0, 8'h10, 8'h11);
    drive("rw10_old", 1'b1, 1'b1, 8'h10, 8'h22);
    drive("rw10_new", 1'b0, 1'b1, 8'h10, 8'h00);

    // Address boundaries
    drive("wr_ff", 1'b1, 1'b0, 8'hFF, 8'hA5);
    drive("wr_00", 1'b1, 1'b0, 8'h00, 8'h5A);
    drive("rd_ff", 1'b0, 1'b1, 8'hFF, 8'h00);
    drive("rd_00", 1'b0, 1'b1, 8'h00, 8'h00);
    sweep("boundary_sweep");

    // Read disabled forces zero
    drive("rd_off6", 1'b0, 1'b0, 8'h06, 8'h00);
    drive("rd_off_ff", 1'b0, 1'b0, 8'hFF, 8'h00);

    // Reset between edges while a write to 6 is pending
    @(posedge clk);
    #1;
    WriteMem    = 1'b1;
    ReadMem     = 1'b1;
    DataAddress = 8'h06;
    DataIn      = 8'h00;
    #1 reset_n = 1'b0;
    push_exp("midreset_out", 1'b0, 6, 8'h00);
`ifdef DATA_MEM_RESET_CLEAR_EN
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
`endif
    @(posedge clk);
    #1;
    push_exp("midreset_hold", 1'b0, 6, 8'h00);
    @(negedge clk);
    #1;
    reset_n  = 1'b1;
    WriteMem = 1'b0;
    drive("after_reset6", 1'b0, 1'b1, 8'h06, 8'h00);
    sweep("midreset_sweep");
    drive("resume_wr", 1'b1, 1'b1, 8'h30, 8'h96);
    drive("resume_rd", 1'b0, 1'b1, 8'h30, 8'h00);

    // Randomized traffic, biased toward the address extremes
    for (int n = 0; n < 400; n++) begin
      logic [7:0] a;
      int         sel;
      sel = int'($urandom_range(0, 9));
      a   = (sel == 0) ? 8'h00 : (sel == 1) ? 8'hFF : 8'($urandom);
      drive("rand", 1'($urandom), ($urandom_range(0, 3) != 0), a, 8'($urandom));
    end
    drive("rand_end", 1'b0, 1'b0, 8'h00, 8'h00);
    sweep("final_sweep");

    @(negedge clk);
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
